// File: rtl/tdm_demux_4ch_pkg.sv
`default_nettype none
// =============================================================================
// Module      : tdm_demux_4ch_pkg
// Description : Shared types and constants for the 4-channel TDM demultiplexer.
// Revision    : 1.0 - initial release
// =============================================================================
package tdm_demux_4ch_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int         c_DEFAULT_WIDTH = 8;
    localparam logic [2:0] c_MISS_LIMIT    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/slot_counter.sv
`default_nettype none
// =============================================================================
// Module      : slot_counter
// Description : 2-bit enable-qualified loadable modulo-4 counter, async reset.
// Revision    : 1.0 - initial release
// =============================================================================
module slot_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic [1:0] count
);

    logic [1:0] r_count;

    // Load wins over increment so a re-alignment always lands on the new slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= r_count + 2'd1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/tdm_demux_4ch.sv
`default_nettype none
// =============================================================================
// Module      : tdm_demux_4ch
// Description : Frame-synchronised 4-channel TDM demultiplexer with lock FSM.
// Revision    : 1.0 - initial release
// =============================================================================
module tdm_demux_4ch
    import tdm_demux_4ch_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int NCH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic [3:0]       ch_stb,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_ch     [NCH];
    logic [WIDTH-1:0] w_ch_nxt [NCH];
    logic [3:0]       r_stb;
    logic [3:0]       w_stb_nxt;
    logic             r_frame_valid;
    logic             w_frame_valid_nxt;
    logic             r_sync_err;
    logic             w_sync_err_nxt;
    logic [2:0]       r_miss;
    logic [2:0]       w_miss_nxt;
    logic [2:0]       r_loaded;      // slots 0..2 loaded in the current frame
    logic [2:0]       w_loaded_nxt;
    logic [1:0]       w_slot;
    logic             w_slot_en;
    logic             w_slot_load;
    logic [2:0]       w_miss_inc;

    slot_counter u_slot_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (w_slot_en),
        .load     (w_slot_load),
        .load_val (2'd1),
        .count    (w_slot)
    );

    assign w_miss_inc = r_miss + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_ch_nxt          = r_ch;
        w_stb_nxt         = 4'b0000;
        w_frame_valid_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;
        w_miss_nxt        = r_miss;
        w_loaded_nxt      = r_loaded;
        w_slot_en         = 1'b0;
        w_slot_load       = 1'b0;

        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        w_ch_nxt[0]  = din;
                        w_stb_nxt    = 4'b0001;
                        w_slot_load  = 1'b1;
                        w_miss_nxt   = 3'd0;
                        w_loaded_nxt = 3'b001;
                        w_state_nxt  = LOCK;
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        // Sync anywhere re-aligns to slot 0; off-slot is an error.
                        w_ch_nxt[0]    = din;
                        w_stb_nxt      = 4'b0001;
                        w_slot_load    = 1'b1;
                        w_miss_nxt     = 3'd0;
                        w_loaded_nxt   = 3'b001;
                        w_sync_err_nxt = (w_slot != 2'd0);
                    end else begin
                        w_ch_nxt[w_slot] = din;
                        w_stb_nxt        = 4'b0001 << w_slot;
                        w_slot_en        = 1'b1;
                        if (w_slot == 2'd0) begin
                            w_loaded_nxt = 3'b001;
                            if (w_miss_inc == c_MISS_LIMIT) begin
                                w_miss_nxt  = 3'd0;
                                w_state_nxt = HUNT;
                            end else begin
                                w_miss_nxt = w_miss_inc;
                            end
                        end else if (w_slot == 2'd3) begin
                            w_frame_valid_nxt = (r_loaded == 3'b111);
                            w_loaded_nxt      = 3'b000;
                        end else begin
                            w_loaded_nxt = r_loaded | (3'b001 << w_slot);
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_ch[k] <= '0;
            end
            r_stb         <= 4'b0000;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_miss        <= 3'd0;
            r_loaded      <= 3'b000;
        end else begin
            r_ch          <= w_ch_nxt;
            r_stb         <= w_stb_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sync_err    <= w_sync_err_nxt;
            r_miss        <= w_miss_nxt;
            r_loaded      <= w_loaded_nxt;
        end
    end

    assign ch0         = r_ch[0];
    assign ch1         = r_ch[1];
    assign ch2         = r_ch[2];
    assign ch3         = r_ch[3];
    assign ch_stb      = r_stb;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_4ch.sv
`default_nettype none
// =============================================================================
// Module      : tb_tdm_demux_4ch
// Description : Directed self-checking bench for tdm_demux_4ch.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_tdm_demux_4ch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] ch0, ch1, ch2, ch3;
    logic [3:0] ch_stb;
    logic       frame_valid, locked, sync_err;

    int checks   = 0;
    int failures = 0;

    tdm_demux_4ch #(.WIDTH(8), .NCH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .ch_stb      (ch_stb),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of input, then return 1 time unit after the active edge.
    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ch0, ch1, ch2, ch3} !== 32'h0 || ch_stb !== 4'b0 || frame_valid !== 1'b0 ||
            locked !== 1'b0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ch=%h stb=%b fv=%b lk=%b se=%b expected all zero",
                     {ch0, ch1, ch2, ch3}, ch_stb, frame_valid, locked, sync_err);
        end
    endtask

    task automatic test_normal_frame();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int fv_count = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, vals[i]);
            fv_count += int'(frame_valid);
            checks++;
            if (ch_stb !== (4'b0001 << i) || locked !== 1'b1 || frame_valid !== (i == 3)) begin
                failures++;
                $display("FAIL normal_step%0d: stb=%b lk=%b fv=%b expected stb=%b lk=1 fv=%b",
                         i, ch_stb, locked, frame_valid, 4'b0001 << i, i == 3);
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        fv_count += int'(frame_valid);
        checks++;
        if ({ch0, ch1, ch2, ch3} !== 32'h11223344 || fv_count != 1 || ch_stb !== 4'b0) begin
            failures++;
            $display("FAIL normal_frame: ch=%h fv_count=%0d stb=%b expected 11223344 1 0000",
                     {ch0, ch1, ch2, ch3}, fv_count, ch_stb);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int fv_count = 0;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, vals[i]);
            fv_count += int'(frame_valid);
            if (ch_stb !== (4'b0001 << i)) bad++;
            for (int g = 0; g < 2; g++) begin
                drive(1'b0, 1'b0, 8'hEE);
                fv_count += int'(frame_valid);
                if (ch_stb !== 4'b0) bad++;
            end
        end
        checks++;
        if ({ch0, ch1, ch2, ch3} !== 32'h11223344 || fv_count != 1 || bad != 0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL gapped: ch=%h fv_count=%0d stb_errs=%0d lk=%b expected 11223344 1 0 1",
                     {ch0, ch1, ch2, ch3}, fv_count, bad, locked);
        end
    endtask

    task automatic test_hunt_discard();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'hAA);
            if (ch_stb !== 4'b0 || locked !== 1'b0 || ch0 !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hunt_discard: %0d cycles with stb/lock/ch0 activity, expected 0", bad);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, 8'(i + 1));
        end
        checks++;
        if ({ch0, ch1, ch2, ch3} !== 32'h01020304 || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL hunt_frame: ch=%h fv=%b expected 01020304 1",
                     {ch0, ch1, ch2, ch3}, frame_valid);
        end
    endtask

    task automatic test_misaligned_sync();
        int fv_count = 0;
        // Continues from a locked state with the slot counter at 0.
        drive(1'b1, 1'b0, 8'h66);
        fv_count += int'(frame_valid);
        drive(1'b1, 1'b0, 8'h77);
        fv_count += int'(frame_valid);
        drive(1'b1, 1'b1, 8'h55);
        fv_count += int'(frame_valid);
        checks++;
        if (sync_err !== 1'b1 || ch0 !== 8'h55 || ch_stb !== 4'b0001 || locked !== 1'b1) begin
            failures++;
            $display("FAIL misalign_sync: se=%b ch0=%h stb=%b lk=%b expected 1 55 0001 1",
                     sync_err, ch0, ch_stb, locked);
        end
        drive(1'b1, 1'b0, 8'h88);
        fv_count += int'(frame_valid);
        checks++;
        if (sync_err !== 1'b0 || ch1 !== 8'h88 || ch_stb !== 4'b0010 || fv_count != 0) begin
            failures++;
            $display("FAIL misalign_realign: se=%b ch1=%h stb=%b fv_count=%0d expected 0 88 0010 0",
                     sync_err, ch1, ch_stb, fv_count);
        end
        drive(1'b1, 1'b0, 8'h99);
        drive(1'b1, 1'b0, 8'hBB);
        checks++;
        if (frame_valid !== 1'b1 || {ch0, ch1, ch2, ch3} !== 32'h558899BB) begin
            failures++;
            $display("FAIL misalign_next_frame: fv=%b ch=%h expected 1 558899BB",
                     frame_valid, {ch0, ch1, ch2, ch3});
        end
    endtask

    task automatic test_loss_of_lock();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 8'h10 + 8'(i));
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h80 + i));
            if (i < 12) begin
                if (ch_stb !== (4'b0001 << (i % 4)) || locked !== 1'b1 ||
                    frame_valid !== ((i % 4) == 3)) bad++;
            end else if (i == 12) begin
                checks++;
                if (locked !== 1'b0 || ch_stb !== 4'b0001 || ch0 !== 8'h8C) begin
                    failures++;
                    $display("FAIL lock_drop: lk=%b stb=%b ch0=%h expected 0 0001 8c",
                             locked, ch_stb, ch0);
                end
            end else begin
                if (ch_stb !== 4'b0 || locked !== 1'b0 || frame_valid !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL loss_sequence: %0d unexpected cycles, expected 0", bad);
        end
        drive(1'b1, 1'b1, 8'h5A);
        checks++;
        if (locked !== 1'b1 || ch0 !== 8'h5A || ch_stb !== 4'b0001) begin
            failures++;
            $display("FAIL relock: lk=%b ch0=%h stb=%b expected 1 5a 0001", locked, ch0, ch_stb);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        do_reset();
        drive(1'b1, 1'b1, 8'h11);
        drive(1'b1, 1'b0, 8'h22);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ch0, ch1, ch2, ch3} !== 32'h0 || ch_stb !== 4'b0 || locked !== 1'b0 ||
            frame_valid !== 1'b0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: ch=%h stb=%b lk=%b fv=%b se=%b expected all zero",
                     {ch0, ch1, ch2, ch3}, ch_stb, locked, frame_valid, sync_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'h33);
        if (ch_stb !== 4'b0 || frame_valid !== 1'b0 || locked !== 1'b0) bad++;
        drive(1'b1, 1'b0, 8'h44);
        if (ch_stb !== 4'b0 || frame_valid !== 1'b0 || locked !== 1'b0) bad++;
        checks++;
        if (bad != 0 || ch2 !== 8'h00 || ch3 !== 8'h00) begin
            failures++;
            $display("FAIL after_reset: %0d active cycles ch2=%h ch3=%h expected 0 00 00",
                     bad, ch2, ch3);
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_gapped();
        test_hunt_discard();
        test_misaligned_sync();
        test_loss_of_lock();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
